// File: rtl/digipot_prog_sched.sv
// Shadow table of digipot wiper codes with per-entry dirty bits; dirty entries are
// scheduled round-robin onto a shared 11-bit serial bus (3-bit address, 8-bit code, MSB first).
module digipot_prog_sched #(
    parameter int          NUM_CS     = 2,
    parameter int          NUM_CH     = 4,
    parameter int          HALF_DIV   = 2,
    parameter int          GAP        = 4,
    parameter logic [7:0]  RESET_CODE = 8'h80
) (
    input  logic              fpga_clock,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_cs,
    input  logic [2:0]        wr_ch,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              inhibit,
    output logic              busy,
    output logic              pending,
    output logic              frame_done,
    output logic              res_clk,
    output logic              res_sdi,
    output logic [NUM_CS-1:0] res_cs_n
);
    localparam int          N       = NUM_CS * NUM_CH;
    localparam int          IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0]  NCS_L   = 4'(NUM_CS);
    localparam logic [3:0]  NCH_L   = 4'(NUM_CH);
    localparam logic [15:0] HALF_LD = 16'(HALF_DIV - 1);
    localparam logic [15:0] GAP_LD  = 16'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SCAN, ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD, ST_GAP
    } state_t;

    state_t             state_r;
    logic [15:0]        cnt_r;
    logic [3:0]         bit_r;
    logic [10:0]        frame_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [7:0]         table_r [N];
    logic [N-1:0]       dirty_r;

    logic               wr_ok_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic [10:0]        pick_frame_s;
    logic [NUM_CS-1:0]  pick_cs_n_s;
    logic [IDX_W-1:0]   next_rr_s;
    logic               scan_clr_s;
    logic [N-1:0]       dirty_next_s;
    int                 scan_j_s;

    // Write decode: out-of-range chip or channel indices are dropped.
    always_comb begin
        wr_ok_s  = ({1'b0, wr_cs} < NCS_L) && ({1'b0, wr_ch} < NCH_L);
        wr_idx_s = IDX_W'(int'(wr_cs) * NUM_CH + int'(wr_ch));
    end

    // Round-robin pick: lowest offset from rr_ptr wins, so iterate from the far end down.
    always_comb begin
        found_s  = 1'b0;
        pick_s   = '0;
        scan_j_s = 0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_j_s = int'(rr_ptr_r) + k;
            scan_j_s = (scan_j_s >= N) ? scan_j_s - N : scan_j_s;
            found_s  = found_s | dirty_r[IDX_W'(scan_j_s)];
            pick_s   = dirty_r[IDX_W'(scan_j_s)] ? IDX_W'(scan_j_s) : pick_s;
        end
        pick_frame_s = {3'(int'(pick_s) % NUM_CH), table_r[pick_s]};
        for (int c = 0; c < NUM_CS; c++) begin
            pick_cs_n_s[c] = (c != int'(pick_s) / NUM_CH);
        end
        next_rr_s  = (int'(pick_s) == N - 1) ? '0 : IDX_W'(int'(pick_s) + 1);
        scan_clr_s = (state_r == ST_SCAN) && found_s;
    end

    // Dirty update: a write or flush in the scan cycle overrides the scan's clear.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dirty_next_s[i] = flush
                            | (wr_en && wr_ok_s && (wr_idx_s == IDX_W'(i)))
                            | (dirty_r[i] && !(scan_clr_s && (pick_s == IDX_W'(i))));
        end
    end

    // Shadow table, dirty bits and pending flag.
    always_ff @(posedge fpga_clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) table_r[i] <= RESET_CODE;
            dirty_r <= '1;
            pending <= 1'b1;
        end else begin
            if (wr_en && wr_ok_s) table_r[wr_idx_s] <= wr_data;
            dirty_r <= dirty_next_s;
            pending <= |dirty_r;
        end
    end

    // Frame sequencer with registered bus outputs.
    always_ff @(posedge fpga_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'd0;
            bit_r      <= 4'd0;
            frame_r    <= 11'd0;
            rr_ptr_r   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            res_clk    <= 1'b0;
            res_sdi    <= 1'b0;
            res_cs_n   <= '1;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pending && !inhibit) state_r <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (found_s) begin
                        frame_r  <= pick_frame_s;
                        rr_ptr_r <= next_rr_s;
                        res_cs_n <= pick_cs_n_s;
                        res_sdi  <= pick_frame_s[10];
                        res_clk  <= 1'b0;
                        cnt_r    <= HALF_LD;
                        busy     <= 1'b1;
                        state_r  <= ST_SETUP;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == 16'd0) begin
                        bit_r   <= 4'd10;
                        res_sdi <= frame_r[10];
                        cnt_r   <= HALF_LD;
                        state_r <= ST_SHIFT_LO;
                    end else begin
                        cnt_r   <= cnt_r - 16'd1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (cnt_r == 16'd0) begin
                        res_clk <= 1'b1;
                        cnt_r   <= HALF_LD;
                        state_r <= ST_SHIFT_HI;
                    end else begin
                        cnt_r   <= cnt_r - 16'd1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (cnt_r != 16'd0) begin
                        cnt_r   <= cnt_r - 16'd1;
                    end else if (bit_r == 4'd0) begin
                        res_clk <= 1'b0;
                        cnt_r   <= HALF_LD;
                        state_r <= ST_HOLD;
                    end else begin
                        res_clk <= 1'b0;
                        bit_r   <= bit_r - 4'd1;
                        res_sdi <= frame_r[bit_r - 4'd1];
                        cnt_r   <= HALF_LD;
                        state_r <= ST_SHIFT_LO;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == 16'd0) begin
                        res_cs_n   <= '1;
                        res_sdi    <= 1'b0;
                        frame_done <= 1'b1;
                        cnt_r      <= GAP_LD;
                        state_r    <= ST_GAP;
                    end else begin
                        cnt_r      <= cnt_r - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == 16'd0) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    res_cs_n <= '1;
                    res_clk  <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digipot_prog_sched.sv
// Bench for digipot_prog_sched: a table/round-robin reference model predicts frames into a
// scoreboard queue; an independent bus monitor decodes frames and compares on CS release.
module tb_digipot_prog_sched;
    localparam int NUM_CS   = 2;
    localparam int NUM_CH   = 4;
    localparam int HALF_DIV = 2;
    localparam int GAP      = 4;
    localparam int N        = NUM_CS * NUM_CH;

    logic              fpga_clock = 1'b0;
    logic              rst_n      = 1'b0;
    logic              wr_en      = 1'b0;
    logic [2:0]        wr_cs      = 3'd0;
    logic [2:0]        wr_ch      = 3'd0;
    logic [7:0]        wr_data    = 8'd0;
    logic              flush      = 1'b0;
    logic              inhibit    = 1'b0;
    logic              busy, pending, frame_done, res_clk, res_sdi;
    logic [NUM_CS-1:0] res_cs_n;

    digipot_prog_sched #(.NUM_CS(NUM_CS), .NUM_CH(NUM_CH), .HALF_DIV(HALF_DIV), .GAP(GAP),
                         .RESET_CODE(8'h80)) dut (
        .fpga_clock(fpga_clock), .rst_n(rst_n), .wr_en(wr_en), .wr_cs(wr_cs), .wr_ch(wr_ch),
        .wr_data(wr_data), .flush(flush), .inhibit(inhibit), .busy(busy), .pending(pending),
        .frame_done(frame_done), .res_clk(res_clk), .res_sdi(res_sdi), .res_cs_n(res_cs_n)
    );

    always #5 fpga_clock = ~fpga_clock;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    int frames_seen = 0;

    // expected frame: {chip[2:0], addr[2:0], code[7:0]}
    logic [13:0] sb_q[$];
    logic [7:0]  m_table [N];
    bit          m_dirty [N];
    int          m_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_table[i] = 8'h80;
            m_dirty[i] = 1'b1;
        end
        m_rr = 0;
    endfunction

    function automatic void m_write(input int cs, input int ch, input logic [7:0] d);
        if (cs < NUM_CS && ch < NUM_CH) begin
            m_table[cs * NUM_CH + ch] = d;
            m_dirty[cs * NUM_CH + ch] = 1'b1;
        end
    endfunction

    // Predict every frame the scheduler will emit for the current dirty set.
    function automatic void m_drain();
        int idx;
        forever begin
            idx = -1;
            for (int k = 0; k < N; k++) begin
                if (idx < 0 && m_dirty[(m_rr + k) % N]) idx = (m_rr + k) % N;
            end
            if (idx < 0) break;
            sb_q.push_back({3'(idx / NUM_CH), 3'(idx % NUM_CH), m_table[idx]});
            m_dirty[idx] = 1'b0;
            m_rr = (idx + 1) % N;
        end
    endfunction

    task automatic do_write(input int cs, input int ch, input logic [7:0] d);
        wr_cs = 3'(cs); wr_ch = 3'(ch); wr_data = d; wr_en = 1'b1;
        @(posedge fpga_clock); #1;
        wr_en = 1'b0;
        m_write(cs, ch, d);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge fpga_clock); #1;
        flush = 1'b0;
        for (int i = 0; i < N; i++) m_dirty[i] = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0 && !busy && !pending) begin
                done = 1'b1;
                break;
            end
            @(posedge fpga_clock); #1;
        end
        check(name, {31'd0, done}, 32'd1);
        sb_q.delete();
    endtask

    task automatic wait_cs_low(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_cs_n != '1) begin
                seen = 1'b1;
                break;
            end
            @(posedge fpga_clock); #1;
        end
        check("cs_low_seen", {31'd0, seen}, 32'd1);
    endtask

    // Bus monitor: decodes each CS-low window and checks it against the scoreboard head.
    initial begin
        logic [2:0]  chip;
        logic [10:0] bits;
        logic [13:0] exp;
        logic [NUM_CS-1:0] first_cs;
        int  edges, lowc, highc;
        bit  in_frame, gap_valid, bad;
        logic prev_clk, prev_sdi;
        in_frame = 0; gap_valid = 0; bad = 0; highc = 0; edges = 0; lowc = 0;
        prev_clk = 0; prev_sdi = 0; chip = 3'd0; bits = 11'd0; first_cs = '1;
        forever begin
            @(negedge fpga_clock);
            if (!rst_n) begin
                in_frame = 0; gap_valid = 0; highc = 0; prev_clk = 1'b0;
                continue;
            end
            if (frame_done) fd_count++;
            if (res_cs_n != '1) begin
                if (!in_frame) begin
                    in_frame = 1; edges = 0; bits = 11'd0; lowc = 0; bad = 0;
                    first_cs = res_cs_n;
                    if ($countones(~res_cs_n) != 1) bad = 1;
                    for (int c = NUM_CS - 1; c >= 0; c--) if (!res_cs_n[c]) chip = 3'(c);
                    if (gap_valid) check("gap_cycles", {31'd0, highc >= GAP + 2}, 32'd1);
                end else begin
                    if (res_cs_n != first_cs) bad = 1;
                    if (prev_clk && res_clk && res_sdi != prev_sdi) bad = 1;
                end
                lowc++;
                if (res_clk && !prev_clk) begin
                    bits = {bits[9:0], res_sdi};
                    edges++;
                end
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: chip %0d bits 0x%0h with no frame expected", chip, bits);
                    end else begin
                        exp = sb_q.pop_front();
                        check("frame_chip", {29'd0, chip}, {29'd0, exp[13:11]});
                        check("frame_bits", {21'd0, bits}, {21'd0, exp[10:0]});
                        check("frame_edges", edges, 11);
                        check("frame_cs_low_cycles", lowc, 24 * HALF_DIV);
                        check("frame_protocol_ok", {31'd0, bad}, 32'd0);
                        check("frame_done_at_cs_rise", {31'd0, frame_done}, 32'd1);
                    end
                    gap_valid = 1; highc = 0;
                end
                highc++;
            end
            prev_clk = res_clk;
            prev_sdi = res_sdi;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, act, k, cs, ch;
        logic [7:0] d;
        m_reset();

        // Reset state
        repeat (3) @(posedge fpga_clock);
        #1;
        check("rst_cs_n", {30'd0, res_cs_n}, {30'd0, 2'b11});
        check("rst_res_clk", {31'd0, res_clk}, 32'd0);
        check("rst_res_sdi", {31'd0, res_sdi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd1);

        // Initial programming of every entry with the reset code
        m_drain();
        rst_n = 1'b1;
        wait_drain("init_drain", 2000);
        check("init_pending_clear", {31'd0, pending}, 32'd0);

        // Single directed write: cs1 ch2 0x5A -> bits 010_01011010
        do_write(1, 2, 8'h5A);
        m_drain();
        wait_drain("single_write_drain", 500);

        // Out-of-range writes change nothing
        do_write(2, 0, 8'h11);
        do_write(0, 5, 8'h22);
        repeat (5) @(posedge fpga_clock);
        #1;
        check("oob_no_pending", {31'd0, pending}, 32'd0);

        // Inhibit holds off three dirty entries
        inhibit = 1'b1;
        for (int i = 0; i < 3; i++) do_write(i % NUM_CS, (i * 3) % NUM_CH, 8'($urandom));
        act = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge fpga_clock); #1;
            if (res_cs_n != '1) act++;
        end
        check("inhibit_no_cs", act, 0);
        check("inhibit_pending", {31'd0, pending}, 32'd1);
        m_drain();
        inhibit = 1'b0;
        wait_drain("inhibit_release_drain", 1000);

        // Inhibit raised mid-frame: frame finishes, next one waits
        inhibit = 1'b1;
        do_write(0, 1, 8'h3C);
        do_write(1, 3, 8'hC3);
        m_drain();
        inhibit = 1'b0;
        wait_cs_low(100);
        repeat (5) @(posedge fpga_clock);
        #1;
        inhibit = 1'b1;
        cnt = 0;
        while (sb_q.size() > 1 && cnt < 300) begin
            @(posedge fpga_clock); #1;
            cnt++;
        end
        act = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge fpga_clock); #1;
            if (res_cs_n != '1) act++;
        end
        check("midframe_inhibit_no_cs", act, 0);
        check("midframe_inhibit_queue", sb_q.size(), 1);
        inhibit = 1'b0;
        wait_drain("midframe_inhibit_drain", 500);

        // Write the entry being scanned: old code first, then the new one
        inhibit = 1'b1;
        do_write(1, 1, 8'h42);
        m_drain();
        repeat (3) @(posedge fpga_clock);
        #1;
        inhibit = 1'b0;
        @(posedge fpga_clock); #1;
        do_write(1, 1, 8'hFF);
        m_drain();
        wait_drain("scan_collision_drain", 500);

        // Randomized batches under inhibit, with occasional flush and out-of-range writes
        for (int r = 0; r < 6; r++) begin
            inhibit = 1'b1;
            k = $urandom_range(5, 1);
            for (int i = 0; i < k; i++) begin
                cs = $urandom_range(2, 0);
                ch = $urandom_range(4, 0);
                d  = 8'($urandom);
                do_write(cs, ch, d);
            end
            if ($urandom_range(3, 0) == 0) do_flush();
            m_drain();
            inhibit = 1'b0;
            wait_drain("random_drain", 3000);
        end

        // Reset mid-shift: outputs drop asynchronously, then full re-init
        inhibit = 1'b1;
        do_write(0, 3, 8'h0F);
        do_flush();
        m_drain();
        inhibit = 1'b0;
        wait_cs_low(100);
        repeat (12) @(posedge fpga_clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_cs_n", {30'd0, res_cs_n}, {30'd0, 2'b11});
        check("midreset_res_clk", {31'd0, res_clk}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        m_reset();
        m_drain();
        repeat (3) @(posedge fpga_clock);
        #1;
        rst_n = 1'b1;
        wait_drain("reinit_drain", 2000);
        check("final_pending", {31'd0, pending}, 32'd0);

        repeat (5) @(posedge fpga_clock);
        #1;
        check("frame_done_count", fd_count, frames_seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
